// File: rtl/fsm_4s2i1o_pkg.sv
// Shared definitions for the 4-state/2-input/1-output Moore FSM (states A..D, out=1 only in D).
// Provides the state encoding, the next-state table and the Moore output function,
// plus the control-state type used by the steering driver.
package fsm_4s2i1o_pkg;

  localparam logic [1:0] StateA = 2'd0;
  localparam logic [1:0] StateB = 2'd1;
  localparam logic [1:0] StateC = 2'd2;
  localparam logic [1:0] StateD = 2'd3;

  typedef enum logic [1:0] {
    CtrlIdle  = 2'd0,
    CtrlSteer = 2'd1,
    CtrlResp  = 2'd2
  } ctrl_state_e;

  // Input 10 always lands in A and 11 always lands in D; 01 reaches B except from C (goes to D);
  // 00 reaches C from B/D and A from A/C.
  function automatic logic [1:0] fsm_4s2i1o_next(input logic [1:0] state,
                                                  input logic [1:0] fsm_in);
    logic [1:0] nxt;
    case (fsm_in)
      2'b10:   nxt = StateA;
      2'b11:   nxt = StateD;
      2'b01:   nxt = (state == StateC) ? StateD : StateB;
      default: nxt = ((state == StateB) || (state == StateD)) ? StateC : StateA;
    endcase
    return nxt;
  endfunction

  function automatic logic fsm_4s2i1o_out(input logic [1:0] state);
    return (state == StateD);
  endfunction

endpackage

// File: rtl/fsm_4s2i1o_steer_driver_if.sv
// Request/response bus of the steering driver.
//   req_val/req_rdy/req_target    : target-state request (requester -> driver)
//   resp_val/resp_rdy             : response handshake (driver -> requester)
//   resp_steps/resp_state         : transitions used and state reached
// master = requester side, slave = driver side.
interface fsm_4s2i1o_steer_driver_if;
  logic       req_val;
  logic       req_rdy;
  logic [1:0] req_target;
  logic       resp_val;
  logic       resp_rdy;
  logic [1:0] resp_steps;
  logic [1:0] resp_state;

  modport master (
    output req_val, req_target, resp_rdy,
    input  req_rdy, resp_val, resp_steps, resp_state
  );

  modport slave (
    input  req_val, req_target, resp_rdy,
    output req_rdy, resp_val, resp_steps, resp_state
  );
endinterface

// File: rtl/fsm_4s2i1o_shadow.sv
// Shadow model of the driven FSM: follows the FSM state from the input being driven, predicts
// its Moore output and flags any disagreement with the real output.
//   i_clk, i_reset : clock, synchronous active-high reset (shared with the driven FSM)
//   i_fsm_in       : input currently driven onto the FSM
//   i_fsm_out      : FSM's actual Moore output
//   o_state        : current shadow state
//   o_err          : sticky output-mismatch flag, cleared only by reset
module fsm_4s2i1o_shadow
  import fsm_4s2i1o_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [1:0] i_fsm_in,
  input  logic       i_fsm_out,
  output logic [1:0] o_state,
  output logic       o_err
);

  logic [1:0] r_state;
  logic       r_err;
  logic [1:0] w_state_nxt;
  logic       w_pred_out;

  always_comb begin
    w_state_nxt = fsm_4s2i1o_next(r_state, i_fsm_in);
    w_pred_out  = fsm_4s2i1o_out(r_state);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= StateA;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_err   <= r_err | (i_fsm_out != w_pred_out);
    end
  end

  assign o_state = r_state;
  assign o_err   = r_err;

endmodule

// File: rtl/fsm_4s2i1o_steer_driver.sv
// Initiator-side steering driver for the 4-state Moore FSM. Accepts a target state over the
// request handshake, drives the FSM input along the shortest path to it (1 or 2 transitions,
// never zero), and returns the step count and reached state over the response handshake.
//   i_clk, i_reset   : clock, synchronous active-high reset (shared with the driven FSM)
//   io_bus           : request/response bus (slave side)
//   o_fsm_in         : combinational drive onto the FSM input
//   i_fsm_out        : FSM's Moore output, checked against the shadow model
//   o_shadow_state   : current shadow of the FSM state
//   o_err            : sticky output-mismatch flag
module fsm_4s2i1o_steer_driver
  import fsm_4s2i1o_pkg::*;
(
  input  logic                          i_clk,
  input  logic                          i_reset,
  fsm_4s2i1o_steer_driver_if.slave      io_bus,
  output logic [1:0]                    o_fsm_in,
  input  logic                          i_fsm_out,
  output logic [1:0]                    o_shadow_state,
  output logic                          o_err
);

  // Input that keeps the FSM where it is. C has no self-loop, so it is parked via D.
  function automatic logic [1:0] steer_hold(input logic [1:0] s);
    logic [1:0] h;
    case (s)
      StateA:  h = 2'b00;
      StateB:  h = 2'b01;
      default: h = 2'b11;
    endcase
    return h;
  endfunction

  // First input on the shortest path from s to t. Targets A, B, D are one hop from everywhere
  // except B from C (goes through D). C is one hop only from B/D; from A go via B, from C via D.
  function automatic logic [1:0] steer_hop(input logic [1:0] s, input logic [1:0] t);
    logic [1:0] h;
    case (t)
      StateA: h = 2'b10;
      StateB: h = 2'b01;
      StateD: h = 2'b11;
      default: begin
        if (s == StateA)      h = 2'b01;
        else if (s == StateC) h = 2'b11;
        else                  h = 2'b00;
      end
    endcase
    return h;
  endfunction

  ctrl_state_e r_ctrl, w_ctrl_nxt;
  logic [1:0]  r_target, w_target_nxt;
  logic [1:0]  r_steps, w_steps_nxt;
  logic [1:0]  r_resp_steps, w_resp_steps_nxt;
  logic [1:0]  r_resp_state, w_resp_state_nxt;
  logic [1:0]  w_shadow;
  logic [1:0]  w_fsm_in;
  logic [1:0]  w_hop;

  fsm_4s2i1o_shadow u_shadow (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_fsm_in  (w_fsm_in),
    .i_fsm_out (i_fsm_out),
    .o_state   (w_shadow),
    .o_err     (o_err)
  );

  always_comb begin
    w_ctrl_nxt       = r_ctrl;
    w_target_nxt     = r_target;
    w_steps_nxt      = r_steps;
    w_resp_steps_nxt = r_resp_steps;
    w_resp_state_nxt = r_resp_state;
    w_hop            = steer_hop(w_shadow, r_target);
    w_fsm_in         = steer_hold(w_shadow);

    case (r_ctrl)
      CtrlIdle: begin
        if (io_bus.req_val) begin
          w_target_nxt = io_bus.req_target;
          w_steps_nxt  = 2'd0;
          w_ctrl_nxt   = CtrlSteer;
        end
      end
      CtrlSteer: begin
        w_fsm_in    = w_hop;
        w_steps_nxt = r_steps + 2'd1;
        // Finish on the cycle whose transition lands on the target.
        if (fsm_4s2i1o_next(w_shadow, w_hop) == r_target) begin
          w_ctrl_nxt       = CtrlResp;
          w_resp_state_nxt = r_target;
          w_resp_steps_nxt = r_steps + 2'd1;
        end
      end
      CtrlResp: begin
        if (io_bus.resp_rdy) w_ctrl_nxt = CtrlIdle;
      end
      default: w_ctrl_nxt = CtrlIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_ctrl       <= CtrlIdle;
      r_target     <= StateA;
      r_steps      <= 2'd0;
      r_resp_steps <= 2'd0;
      r_resp_state <= StateA;
    end else begin
      r_ctrl       <= w_ctrl_nxt;
      r_target     <= w_target_nxt;
      r_steps      <= w_steps_nxt;
      r_resp_steps <= w_resp_steps_nxt;
      r_resp_state <= w_resp_state_nxt;
    end
  end

  assign io_bus.req_rdy    = (r_ctrl == CtrlIdle);
  assign io_bus.resp_val   = (r_ctrl == CtrlResp);
  assign io_bus.resp_steps = r_resp_steps;
  assign io_bus.resp_state = r_resp_state;
  assign o_fsm_in          = w_fsm_in;
  assign o_shadow_state    = w_shadow;

endmodule
